systolic_operand_skewer: RTL and testbench
==========================================

// Module: systolic_operand_skewer
// PURPOSE
//  Upstream feeder for the systolic MAC array. Buffers one tile of ARR_SIZE
//  K-slices: one horizontal vector and one vertical vector per slice.
//  Replays the tile as diagonally skewed wavefronts on the array's horizontal
//  and vertical input buses: row i and column j are each delayed by i or j cycles.
//  Also holds the array mode stable for the whole tile.
// PARAMETERS
//  ARR_SIZE       4   array dimension N; must be >= 2
//  HORIZONTAL_BW  16  operand element width; same width on both buses
// PORTS
//  clk          in   1            clock, rising edge
//  rst          in   1            asynchronous active-low reset
//  flush        in   1            sync abort: return to IDLE, drop tile
//  in_valid     in   1            slice beat valid
//  in_ready     out  1            slice beat accepted when in_valid & in_ready
//  h_slice_in   in   BW*N         element i = row-i operand for this slice
//  v_slice_in   in   BW*N         element j = column-j operand for this slice
//  mode_in      in   1            mode for tile; sampled with beat 0
//  out_valid    out  1            skewed data valid this cycle
//  h_skew_out   out  BW*N         to the array's horizontal input
//  v_skew_out   out  BW*N         to the array's vertical input
//  mode_out     out  1            to the array's i_mode
//  tile_done    out  1            one-cycle pulse after the last wavefront
// BEHAVIOUR
//  Notation
//   - Element e of a vector occupies bits [(e+1)*BW-1 : e*BW].
//   - BW = HORIZONTAL_BW.
//   - Beat k is the k-th accepted beat of a tile.
//  Reset (rst=0, asynchronous)
//   - State = IDLE; beat counter and wave counter = 0.
//   - Buffer cleared.
//   - out_valid, tile_done, mode_out = 0.
//   - h_skew_out, v_skew_out = 0.
//   - in_ready = 1 (combinational from state).
//  State machine (IDLE, LOAD, STREAM)
//   - in_ready = (state==IDLE || state==LOAD) && !flush.
//   - IDLE, on accept:
//     - store beat 0 into buffer slot 0;
//     - latch mode_in into mode_out;
//     - beat counter := 1; go to LOAD.
//   - LOAD, on accept:
//     - store beat into slot cnt; cnt += 1;
//     - in_valid low inserts a bubble with no effect.
//   - LOAD, on accepting beat N-1:
//     - go to STREAM with wave counter t := 0;
//     - on the same edge, register the t=0 wavefront and set out_valid := 1.
//   - STREAM, each cycle t = 0..2N-2 (outputs registered):
//     - h_skew_out element i = buf_h[t-i][i] if 0 <= t-i <= N-1, else 0;
//     - v_skew_out element j = buf_v[t-j][j] under the same rule, else 0.
//   - out_valid is high for exactly 2N-1 consecutive cycles, with no gaps.
//     The array has no backpressure.
//   - Edge ending t = 2N-2:
//     - out_valid := 0; both vectors := 0;
//     - tile_done := 1 for one cycle; state := IDLE.
//   - mode_out holds its value until the next tile's beat 0 is accepted.
//  Boundary conditions
//   - in_valid during STREAM: in_ready=0; nothing stored.
//   - Back-to-back tiles: the next beat 0 is accepted in the tile_done cycle at
//     the earliest.
//   - flush=1 (any state), on the next edge:
//     - state := IDLE; counters := 0;
//     - out_valid, tile_done, vectors := 0; partial tile discarded;
//     - mode_out is retained;
//     - an in_valid beat in the same cycle is not accepted.
//   - Reset mid-LOAD or mid-STREAM: outputs clear immediately (asynchronous).
//  Sizing
//   - Beat counter width: clog2(N+1).
//   - Wave counter width: clog2(2N).
//   - Buffer size: 2*N*N*BW flops.
// TESTING (N=4, BW=16; slice data h[k][i] = 16'hA000 + 16*k + i, v[k][j] = 16'hB000 + 16*k + j)
//  1. Reset
//     - Stimulus: hold rst=0 with random inputs, then release.
//     - Required: all outputs 0 and in_ready=1, both during and after reset.
//  2. Four consecutive beats, then observe 7 valid cycles
//     - t=0: h element 0 = A000, others 0.
//     - t=3: h = {A003, A012, A021, A030} (element 3..0).
//     - t=6: only h element 3 = A033 and v element 3 = B033.
//     - Then: tile_done pulse once; out_valid low.
//  3. Same tile with in_valid bubbles between beats
//     - Required: identical output sequence; out_valid rises the cycle after beat 3.
//  4. Protocol conflicts and back-to-back tiles
//     - Drive in_valid throughout STREAM -> in_ready=0, buffer unchanged.
//     - Second tile starting in the tile_done cycle -> accepted; its wavefronts
//       are correct.
//  5. Flush and mode handling
//     - flush at STREAM t=3 -> next cycle out_valid=0, vectors 0, in_ready=1,
//       no tile_done; a new tile then streams correctly.
//     - mode_in=1 on beat 0 -> mode_out=1 through the whole tile.
//  6. Async reset mid-LOAD
//     - Stimulus: rst low after beat 2, then release.
//     - Required: a fresh 4-beat load is needed before any out_valid.

Source files
------------

// File: rtl/systolic_operand_skewer.sv
// ---------------------------------------------------------------------------
// systolic_operand_skewer
//
// Upstream feeder for the systolic MAC array. Collects one tile of ARR_SIZE
// K-slices (a horizontal and a vertical operand vector per slice), then
// replays the tile as diagonally skewed wavefronts so that row i and column j
// of the array see their operands delayed by i and j cycles respectively.
// The array mode captured with the first beat is held stable for the tile.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   flush       in   synchronous abort: back to IDLE, partial tile dropped
//   in_valid    in   slice beat valid
//   in_ready    out  beat accepted when in_valid & in_ready (combinational)
//   h_slice_in  in   BW*N, element i = row-i operand for this slice
//   v_slice_in  in   BW*N, element j = column-j operand for this slice
//   mode_in     in   tile mode, sampled with beat 0
//   out_valid   out  skewed wavefront valid (2N-1 consecutive cycles)
//   h_skew_out  out  BW*N, to the array's horizontal input
//   v_skew_out  out  BW*N, to the array's vertical input
//   mode_out    out  to the array's mode input
//   tile_done   out  one-cycle pulse after the last wavefront
// ---------------------------------------------------------------------------
module systolic_operand_skewer #(
    parameter int ARR_SIZE      = 4,
    parameter int HORIZONTAL_BW = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] h_slice_in,
    input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] v_slice_in,
    input  logic                              mode_in,
    output logic                              out_valid,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] h_skew_out,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] v_skew_out,
    output logic                              mode_out,
    output logic                              tile_done
);

    localparam int N      = ARR_SIZE;
    localparam int BW     = HORIZONTAL_BW;
    localparam int VW     = N * BW;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int WAVE_W = $clog2(2 * N);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(N - 1);
    localparam logic [WAVE_W-1:0] LAST_WAVE = WAVE_W'(2 * N - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAVE_W-1:0] wave_q, wave_d;
    logic [VW-1:0]     buf_h_q [N];
    logic [VW-1:0]     buf_h_d [N];
    logic [VW-1:0]     buf_v_q [N];
    logic [VW-1:0]     buf_v_d [N];
    logic              out_valid_q, out_valid_d;
    logic [VW-1:0]     h_out_q, h_out_d;
    logic [VW-1:0]     v_out_q, v_out_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;

    logic              accept_s;
    logic [WAVE_W-1:0] wave_sel_s;
    logic [VW-1:0]     wave_h_s;
    logic [VW-1:0]     wave_v_s;

    assign in_ready   = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && !flush;
    assign accept_s   = in_valid && in_ready;

    assign out_valid  = out_valid_q;
    assign h_skew_out = h_out_q;
    assign v_skew_out = v_out_q;
    assign mode_out   = mode_q;
    assign tile_done  = done_q;

    // Index of the wavefront to register on the coming edge: t=0 when the
    // last beat lands, otherwise the successor of the one on the outputs.
    // Wave 0 only needs slot 0, which is already in the buffer by then.
    always_comb begin
        if (state_q == ST_LOAD) begin
            wave_sel_s = '0;
        end else begin
            wave_sel_s = wave_q + WAVE_W'(1);
        end
    end

    // Build wavefront t: element e comes from slice t-e when that slice exists.
    always_comb begin
        int k;
        wave_h_s = '0;
        wave_v_s = '0;
        k        = 0;
        for (int e = 0; e < N; e++) begin
            k = int'(wave_sel_s) - e;
            if ((k >= 0) && (k < N)) begin
                wave_h_s[e*BW +: BW] = buf_h_q[IDX_W'(k)][e*BW +: BW];
                wave_v_s[e*BW +: BW] = buf_v_q[IDX_W'(k)][e*BW +: BW];
            end else begin
                wave_h_s[e*BW +: BW] = {BW{1'b0}};
                wave_v_s[e*BW +: BW] = {BW{1'b0}};
            end
        end
    end

    // Next-state logic for the load/stream sequencer and its registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wave_d      = wave_q;
        buf_h_d     = buf_h_q;
        buf_v_d     = buf_v_q;
        out_valid_d = out_valid_q;
        h_out_d     = h_out_q;
        v_out_d     = v_out_q;
        mode_d      = mode_q;
        done_d      = 1'b0;

        if (flush) begin
            // Abort: the buffer contents become stale but are simply
            // overwritten by the next tile; the mode is kept on purpose.
            state_d     = ST_IDLE;
            cnt_d       = '0;
            wave_d      = '0;
            out_valid_d = 1'b0;
            h_out_d     = '0;
            v_out_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        buf_h_d[0] = h_slice_in;
                        buf_v_d[0] = v_slice_in;
                        mode_d     = mode_in;
                        cnt_d      = CNT_W'(1);
                        state_d    = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        buf_h_d[IDX_W'(cnt_q)] = h_slice_in;
                        buf_v_d[IDX_W'(cnt_q)] = v_slice_in;
                        if (cnt_q == LAST_BEAT) begin
                            cnt_d       = '0;
                            wave_d      = '0;
                            state_d     = ST_STREAM;
                            out_valid_d = 1'b1;
                            h_out_d     = wave_h_s;
                            v_out_d     = wave_v_s;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_STREAM: begin
                    if (wave_q == LAST_WAVE) begin
                        wave_d      = '0;
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        h_out_d     = '0;
                        v_out_d     = '0;
                        done_d      = 1'b1;
                    end else begin
                        wave_d  = wave_sel_s;
                        h_out_d = wave_h_s;
                        v_out_d = wave_v_s;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    wave_d      = '0;
                    out_valid_d = 1'b0;
                    h_out_d     = '0;
                    v_out_d     = '0;
                end
            endcase
        end
    end

    // State, buffer and output registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wave_q      <= '0;
            out_valid_q <= 1'b0;
            h_out_q     <= '0;
            v_out_q     <= '0;
            mode_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int s = 0; s < N; s++) begin
                buf_h_q[s] <= '0;
                buf_v_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wave_q      <= wave_d;
            out_valid_q <= out_valid_d;
            h_out_q     <= h_out_d;
            v_out_q     <= v_out_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
            for (int s = 0; s < N; s++) begin
                buf_h_q[s] <= buf_h_d[s];
                buf_v_q[s] <= buf_v_d[s];
            end
        end
    end

endmodule

// File: tb/tb_systolic_operand_skewer.sv
module tb_systolic_operand_skewer;

    localparam int N  = 4;
    localparam int BW = 16;
    localparam int VW = N * BW;
    localparam int LASTT = 2 * N - 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] h_slice_in = '0;
    logic [VW-1:0] v_slice_in = '0;
    logic          mode_in = 1'b0;
    logic          out_valid;
    logic [VW-1:0] h_skew_out;
    logic [VW-1:0] v_skew_out;
    logic          mode_out;
    logic          tile_done;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] th [N][N];
    logic [BW-1:0] tv [N][N];
    logic          exp_mode = 1'b0;

    systolic_operand_skewer #(.ARR_SIZE(N), .HORIZONTAL_BW(BW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .h_slice_in(h_slice_in), .v_slice_in(v_slice_in),
        .mode_in(mode_in), .out_valid(out_valid), .h_skew_out(h_skew_out),
        .v_skew_out(v_skew_out), .mode_out(mode_out), .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: row/column e sees slice (t - e) at cycle t, zero outside the tile.
    function automatic logic [VW-1:0] model_h(int t);
        logic [VW-1:0] r = '0;
        for (int e = 0; e < N; e++)
            if (t - e >= 0 && t - e < N) r[e*BW +: BW] = th[t-e][e];
        return r;
    endfunction

    function automatic logic [VW-1:0] model_v(int t);
        logic [VW-1:0] r = '0;
        for (int e = 0; e < N; e++)
            if (t - e >= 0 && t - e < N) r[e*BW +: BW] = tv[t-e][e];
        return r;
    endfunction

    task automatic fill_pattern();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                th[k][i] = 16'hA000 + 16'(16 * k + i);
                tv[k][i] = 16'hB000 + 16'(16 * k + i);
            end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                th[k][i] = 16'($urandom);
                tv[k][i] = 16'($urandom);
            end
    endtask

    // Drives beat k at the current negedge; only beat 0's mode should matter.
    task automatic send_beat(int k, logic m);
        in_valid = 1'b1;
        mode_in  = (k == 0) ? m : 1'($urandom);
        for (int i = 0; i < N; i++) begin
            h_slice_in[i*BW +: BW] = th[k][i];
            v_slice_in[i*BW +: BW] = tv[k][i];
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL beat_ready k=%0d: got %b expected 1", k, in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL load_no_valid k=%0d: got %b expected 0", k, out_valid);
        end
        if (k == 0) exp_mode = m;
    endtask

    task automatic load_tile(bit first_now, bit bubbles, logic m);
        for (int k = 0; k < N; k++) begin
            if (!(first_now && k == 0)) @(negedge clk);
            if (bubbles && k > 0) begin
                in_valid   = 1'b0;
                h_slice_in = {$urandom, $urandom};
                v_slice_in = {$urandom, $urandom};
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL bubble_no_valid k=%0d: got %b expected 0", k, out_valid);
                end
            end
            send_beat(k, m);
        end
    endtask

    // Samples wavefronts t=0..stop_t; with stop_t = 2N-2 also the done cycle.
    task automatic check_stream(bit busy, int stop_t, bit spot);
        for (int t = 0; t <= stop_t; t++) begin
            @(negedge clk);
            if (busy) begin
                in_valid   = 1'b1;
                mode_in    = 1'($urandom);
                h_slice_in = {$urandom, $urandom};
                v_slice_in = {$urandom, $urandom};
                #1;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL busy_ready t=%0d: got %b expected 0", t, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL stream_valid t=%0d: got %b expected 1", t, out_valid);
            end
            checks++;
            if (h_skew_out !== model_h(t)) begin
                errors++; $display("FAIL stream_h t=%0d: got %h expected %h", t, h_skew_out, model_h(t));
            end
            checks++;
            if (v_skew_out !== model_v(t)) begin
                errors++; $display("FAIL stream_v t=%0d: got %h expected %h", t, v_skew_out, model_v(t));
            end
            checks++;
            if (mode_out !== exp_mode || tile_done !== 1'b0) begin
                errors++; $display("FAIL stream_mode_done t=%0d: got mode=%b done=%b expected mode=%b done=0",
                                   t, mode_out, tile_done, exp_mode);
            end
            if (spot && t == 0) begin
                checks++;
                if (h_skew_out !== 64'h0000_0000_0000_A000) begin
                    errors++; $display("FAIL spot_t0: got %h expected 000000000000a000", h_skew_out);
                end
            end
            if (spot && t == 3) begin
                checks++;
                if (h_skew_out !== 64'hA003_A012_A021_A030) begin
                    errors++; $display("FAIL spot_t3: got %h expected a003a012a021a030", h_skew_out);
                end
            end
            if (spot && t == 6) begin
                checks++;
                if (h_skew_out !== 64'hA033_0000_0000_0000 || v_skew_out !== 64'hB033_0000_0000_0000) begin
                    errors++; $display("FAIL spot_t6: got h=%h v=%h expected h=a033000000000000 v=b033000000000000",
                                       h_skew_out, v_skew_out);
                end
            end
        end
        if (stop_t == LASTT) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || tile_done !== 1'b1) begin
                errors++; $display("FAIL done_cycle: got valid=%b done=%b expected valid=0 done=1", out_valid, tile_done);
            end
            checks++;
            if (h_skew_out !== '0 || v_skew_out !== '0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL done_clear: got h=%h v=%h ready=%b expected zeros, ready=1",
                                   h_skew_out, v_skew_out, in_ready);
            end
        end
    endtask

    task automatic check_idle_after();
        @(negedge clk);
        checks++;
        if (tile_done !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL after_done: got done=%b valid=%b expected 0 0", tile_done, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid   = 1'($urandom);
            mode_in    = 1'($urandom);
            h_slice_in = {$urandom, $urandom};
            v_slice_in = {$urandom, $urandom};
            #1;
            checks++;
            if (out_valid !== 1'b0 || tile_done !== 1'b0 || mode_out !== 1'b0 ||
                h_skew_out !== '0 || v_skew_out !== '0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL reset_hold c=%0d: got v=%b d=%b m=%b h=%h vv=%h r=%b expected all 0, ready 1",
                                   c, out_valid, tile_done, mode_out, h_skew_out, v_skew_out, in_ready);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || tile_done !== 1'b0 || mode_out !== 1'b0 ||
            h_skew_out !== '0 || v_skew_out !== '0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: got v=%b d=%b m=%b h=%h vv=%h r=%b expected all 0, ready 1",
                               out_valid, tile_done, mode_out, h_skew_out, v_skew_out, in_ready);
        end
        exp_mode = 1'b0;
    endtask

    task automatic test_stream();
        fill_pattern();
        load_tile(1'b0, 1'b0, 1'b0);
        check_stream(1'b0, LASTT, 1'b1);
        check_idle_after();
    endtask

    task automatic test_bubbles();
        fill_pattern();
        load_tile(1'b0, 1'b1, 1'b1);
        check_stream(1'b0, LASTT, 1'b1);
        check_idle_after();
    endtask

    task automatic test_back_to_back();
        fill_random();
        load_tile(1'b0, 1'b0, 1'b1);
        check_stream(1'b1, LASTT, 1'b0);
        fill_random();
        load_tile(1'b1, 1'b0, 1'b0);
        check_stream(1'b0, LASTT, 1'b0);
        check_idle_after();
    endtask

    task automatic test_flush_mode();
        fill_random();
        load_tile(1'b0, 1'b0, 1'b1);
        check_stream(1'b0, 3, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || h_skew_out !== '0 || v_skew_out !== '0 ||
            in_ready !== 1'b1 || tile_done !== 1'b0 || mode_out !== 1'b1) begin
            errors++; $display("FAIL flush_clear: got v=%b h=%h vv=%h r=%b d=%b m=%b expected 0,0,0,1,0,1",
                               out_valid, h_skew_out, v_skew_out, in_ready, tile_done, mode_out);
        end
        check_idle_after();
        fill_random();
        load_tile(1'b0, 1'b0, 1'b0);
        check_stream(1'b0, LASTT, 1'b0);
        check_idle_after();
    endtask

    task automatic test_reset_mid_load();
        fill_random();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            send_beat(k, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        exp_mode = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || tile_done !== 1'b0 || mode_out !== 1'b0 ||
            h_skew_out !== '0 || v_skew_out !== '0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midload_reset: got v=%b d=%b m=%b h=%h vv=%h r=%b expected all 0, ready 1",
                               out_valid, tile_done, mode_out, h_skew_out, v_skew_out, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        fill_random();
        load_tile(1'b0, 1'b0, 1'b0);
        check_stream(1'b0, LASTT, 1'b0);
        check_idle_after();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bubbles();
        test_back_to_back();
        test_flush_mode();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
